cache_rsp_return: RTL and testbench
===================================

Name: cache_rsp_return

Overview:
- Downstream return stage paired with the keep-order buffer (KOB).
- Collects out-of-order responses from the cache banks into per-bank, per-channel queues.
- For each channel, pops only the bank that the KOB nominates as next-in-order, and delivers the response to the channel through a valid/ready output register.
- Returns a one-cycle ack to the KOB for each delivered response.

Parameters:
- NUM_CH, 3, number of requesting channels.
- NUM_BANK, 4, number of cache banks.
- DATA_W, 32, response payload width.
- RSP_DEPTH, 2, entries per (bank, channel) sub-queue; power of two, ≥2.
- Derived: CH_W=$clog2(NUM_CH)=2, BK_W=$clog2(NUM_BANK)=2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- bank_rsp_valid  in  NUM_BANK  per-bank response valid.
- bank_rsp_ready  out  NUM_BANK  per-bank accept.
- bank_rsp_ch_id  in  NUM_BANK*CH_W  destination channel per bank.
- bank_rsp_data  in  NUM_BANK*DATA_W  payload per bank.
- rob_req  in  NUM_CH  from KOB: channel has an outstanding in-order head.
- rob_bank_id  in  NUM_CH*BK_W  from KOB: bank holding that head.
- rob_ack  out  NUM_CH  to KOB: head consumed this cycle.
- ch_rsp_valid  out  NUM_CH  response valid to channel.
- ch_rsp_ready  in  NUM_CH  channel accepts.
- ch_rsp_data  out  NUM_CH*DATA_W  payload.
- ch_rsp_bank_id  out  NUM_CH*BK_W  source bank of the delivered payload.
- rsp_err  out  1  sticky error (see Optional Feature).

Behaviour:
- Storage: NUM_BANK×NUM_CH FIFOs Q[b][c], RSP_DEPTH deep, each with its own wr/rd pointers and a count of width $clog2(RSP_DEPTH)+1.
- Ingress, per bank b:
  - bank_rsp_ready[b] = ~full(Q[b][ch_id]) when ch_id<NUM_CH, else 1; combinational from bank_rsp_ch_id.
  - valid&ready with a legal ch_id writes Q[b][ch_id] at the edge.
  - An illegal ch_id (≥NUM_CH) is consumed and discarded.
- Output register, per channel c: one stage holding {valid, data, bank_id}.
  - pop_c = rob_req[c] & ~empty(Q[bank_id_c][c]) & (~ch_rsp_valid[c] | ch_rsp_ready[c]).
  - pop_c loads the register from the head of Q[bank_id_c][c] and advances that queue's read pointer.
  - rob_ack[c] = pop_c, combinational, exactly one cycle per delivered response.
  - No pop while the register holds unaccepted data and ch_rsp_ready=0; ch_rsp_valid, data and bank_id stay stable until accepted.
  - ch_rsp_valid drops after acceptance when there is no pop.
  - Full throughput: accept and pop in the same cycle gives back-to-back valid.
- Latency: a bank beat accepted at edge N can pop at edge N+1; ch_rsp_valid is high in the cycle after edge N+1 (2 cycles minimum).
- No write-to-pop bypass on an empty queue.
- Isolation:
  - Channels only ever pop their own Q[*][c], so there is no cross-channel conflict.
  - Banks write distinct Q[b][*], so there is no write conflict.
  - No head-of-line blocking between channels.
- Simultaneous push and pop on the same queue:
  - Allowed, including when full; count is unchanged.
  - Ready is computed from the pre-edge full, so a full queue popped this cycle still shows ready=0 (conservative, no bypass).
- Pointers wrap modulo RSP_DEPTH.
- rob_req with an empty target queue: wait, no ack.
- A change in rob_bank_id while not acked is honoured on the next cycle.
- Reset (asynchronous, mid-operation included):
  - All queues empty, pointers 0.
  - ch_rsp_valid=0, ch_rsp_data=0, ch_rsp_bank_id=0, rsp_err=0.
  - rob_ack=0 and bank_rsp_ready reflect empty queues (1) while rstn=0.
  - In-flight data is discarded.

Optional Feature:
- Macro CACHE_RSP_RETURN_ERR_CHK_EN.
- Defined:
  - rsp_err sets at the edge when a bank beat is accepted with ch_id≥NUM_CH.
  - rsp_err also sets when rob_req[c] is high while ch_rsp_valid[c] is held for more than 255 consecutive cycles (8-bit stall counter per channel, cleared on accept).
  - rsp_err is sticky until reset.
- Undefined: no counters; rsp_err tied to 0; illegal ch_id beats are still silently dropped.

Test Plan:
1. Reset, then bank1 sends ch_id=0, data=0xA5A5_0001 while rob_req[0]=1 with bank_id=1 and ch_rsp_ready[0]=1:
   - rob_ack[0] pulses one cycle after the bank beat.
   - ch_rsp_valid[0]=1 with data 0xA5A5_0001 and bank_id=1 on the next cycle.
2. Out of order: bank2 returns 0x22 for ch1, then bank0 returns 0x00 for ch1; KOB requests bank0 then bank2:
   - Outputs are 0x00 then 0x22.
   - Exactly 2 rob_ack[1] pulses.
3. Backpressure: fill Q[3][2] with 2 beats while rob_req[2]=0:
   - bank_rsp_ready[3]=0 for ch_id=2 and 1 for ch_id=0.
   - Assert rob_req[2] with ch_rsp_ready[2]=0: exactly one pop, then held.
   - Release ready: second beat follows on the next cycle.
4. All 3 channels pop different banks in the same cycle, with banks 0–2 each writing for another channel simultaneously:
   - Three acks in one cycle.
   - No data corruption; counts correct.
5. Assert rstn=0 mid-stream with 2 queued beats and valid outputs:
   - All outputs 0 immediately.
   - After release, rob_req produces no ack until new beats arrive.
6. With CACHE_RSP_RETURN_ERR_CHK_EN: bank0 sends ch_id=3:
   - Beat is dropped.
   - rsp_err=1 from the next cycle and stays 1 until reset.
   - Without the macro, rsp_err stays 0.

Source files
------------

// File: rtl/cache_rsp_return.sv
// cache_rsp_return: return stage behind the keep-order buffer.
// Bank responses land in per-(bank, channel) FIFOs. Each channel pops the
// bank its KOB names as next-in-order into a valid/ready output register
// and acks the KOB for every response it takes.
// Optional: define CACHE_RSP_RETURN_ERR_CHK_EN to enable the sticky rsp_err
// (illegal channel id accepted, or an output stalled > 255 cycles).
module cache_rsp_return #(
  parameter int NUM_CH    = 3,
  parameter int NUM_BANK  = 4,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 2,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int BK_W      = $clog2(NUM_BANK)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_BANK-1:0]      bank_rsp_valid,
  output logic [NUM_BANK-1:0]      bank_rsp_ready,
  input  logic [NUM_BANK*CH_W-1:0] bank_rsp_ch_id,
  input  logic [NUM_BANK*DATA_W-1:0] bank_rsp_data,
  input  logic [NUM_CH-1:0]        rob_req,
  input  logic [NUM_CH*BK_W-1:0]   rob_bank_id,
  output logic [NUM_CH-1:0]        rob_ack,
  output logic [NUM_CH-1:0]        ch_rsp_valid,
  input  logic [NUM_CH-1:0]        ch_rsp_ready,
  output logic [NUM_CH*DATA_W-1:0] ch_rsp_data,
  output logic [NUM_CH*BK_W-1:0]   ch_rsp_bank_id,
  output logic                     rsp_err
);

  // Queue q = bank*NUM_CH + channel
  localparam int NQ    = NUM_BANK * NUM_CH;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NQ-1:0]             q_full;
  logic [NQ-1:0]             q_empty;
  logic [NQ-1:0]             q_push;
  logic [NQ-1:0]             q_pop;
  logic [NQ-1:0][DATA_W-1:0] q_head;
  logic [NUM_CH-1:0]         pop;
`ifdef CACHE_RSP_RETURN_ERR_CHK_EN
  logic [NUM_BANK-1:0]       bank_bad;
  logic [NUM_CH-1:0]         stall_ovf;
`endif

  genvar gi, gj;

  // Per-queue storage, pointers and occupancy
  for (gi = 0; gi < NQ; gi++) begin : g_q
    localparam int B = gi / NUM_CH;
    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  cnt_reg;

    // Payload array; no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
      if (q_push[gi]) mem[wr_ptr_reg] <= bank_rsp_data[B*DATA_W +: DATA_W];
    end

    // Pointers wrap naturally (power-of-two depth); push+pop keeps count
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        cnt_reg    <= '0;
      end else begin
        if (q_push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (q_pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        case ({q_push[gi], q_pop[gi]})
          2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
          2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
          default: cnt_reg <= cnt_reg;
        endcase
      end
    end

    assign q_full[gi]  = (cnt_reg == CNT_W'(RSP_DEPTH));
    assign q_empty[gi] = (cnt_reg == '0);
    assign q_head[gi]  = mem[rd_ptr_reg];
  end

  // Ingress per bank: route by channel id; illegal ids are always accepted
  for (gi = 0; gi < NUM_BANK; gi++) begin : g_in
    logic [CH_W-1:0]   ch_id;
    logic              rdy;
    logic [NUM_CH-1:0] push;

    assign ch_id = bank_rsp_ch_id[gi*CH_W +: CH_W];

    // Ready uses the pre-edge full flag only (no pop-through bypass)
    always_comb begin
      rdy  = 1'b1;
      push = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_id == CH_W'(c)) begin
          rdy     = ~q_full[gi*NUM_CH + c];
          push[c] = bank_rsp_valid[gi] & ~q_full[gi*NUM_CH + c];
        end
      end
    end

    assign bank_rsp_ready[gi]                = rdy;
    assign q_push[gi*NUM_CH +: NUM_CH]       = push;
`ifdef CACHE_RSP_RETURN_ERR_CHK_EN
    assign bank_bad[gi] = bank_rsp_valid[gi] & (int'(ch_id) >= NUM_CH);
`endif
  end

  // Egress per channel: pop the KOB-nominated bank into the output stage
  for (gi = 0; gi < NUM_CH; gi++) begin : g_out
    logic [BK_W-1:0]   bank_sel;
    logic              head_vld;
    logic [DATA_W-1:0] head_data;
    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [BK_W-1:0]   bank_reg;

    assign bank_sel = rob_bank_id[gi*BK_W +: BK_W];

    // Select the head of this channel's queue in the nominated bank
    always_comb begin
      head_vld  = 1'b0;
      head_data = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
        if (bank_sel == BK_W'(b)) begin
          head_vld  = ~q_empty[b*NUM_CH + gi];
          head_data = q_head[b*NUM_CH + gi];
        end
      end
    end

    assign pop[gi] = rob_req[gi] & head_vld & (~valid_reg | ch_rsp_ready[gi]);

    for (gj = 0; gj < NUM_BANK; gj++) begin : g_popq
      assign q_pop[gj*NUM_CH + gi] = pop[gi] & (bank_sel == BK_W'(gj));
    end

    // Output stage: load on pop, hold while stalled, drop once accepted
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        bank_reg  <= '0;
      end else if (pop[gi]) begin
        valid_reg <= 1'b1;
        data_reg  <= head_data;
        bank_reg  <= bank_sel;
      end else if (ch_rsp_ready[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign rob_ack[gi]                          = pop[gi];
    assign ch_rsp_valid[gi]                     = valid_reg;
    assign ch_rsp_data[gi*DATA_W +: DATA_W]     = data_reg;
    assign ch_rsp_bank_id[gi*BK_W +: BK_W]      = bank_reg;

`ifdef CACHE_RSP_RETURN_ERR_CHK_EN
    logic [7:0] stall_cnt_reg;
    logic       stalled;
    assign stalled = rob_req[gi] & valid_reg & ~ch_rsp_ready[gi];

    // Saturating count of consecutive stalled cycles
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                        stall_cnt_reg <= '0;
      else if (!stalled)                stall_cnt_reg <= '0;
      else if (stall_cnt_reg != 8'hFF)  stall_cnt_reg <= stall_cnt_reg + 8'd1;
    end

    assign stall_ovf[gi] = stalled & (stall_cnt_reg == 8'hFF);
`endif
  end

`ifdef CACHE_RSP_RETURN_ERR_CHK_EN
  logic err_reg;

  // Sticky error until reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              err_reg <= 1'b0;
    else if ((|bank_bad) || (|stall_ovf))   err_reg <= 1'b1;
  end

  assign rsp_err = err_reg;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_rsp_return.sv
// Self-checking bench for cache_rsp_return: directed scenarios plus a
// randomized run checked against a queue-based model of the return stage.
`timescale 1ns/1ps
module tb_cache_rsp_return;
  localparam int NUM_CH = 3, NUM_BANK = 4, DATA_W = 32, RSP_DEPTH = 2;
  localparam int CH_W = 2, BK_W = 2;
`ifdef CACHE_RSP_RETURN_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic [NUM_BANK-1:0]        bank_rsp_valid, bank_rsp_ready;
  logic [NUM_BANK*CH_W-1:0]   bank_rsp_ch_id;
  logic [NUM_BANK*DATA_W-1:0] bank_rsp_data;
  logic [NUM_CH-1:0]          rob_req, rob_ack, ch_rsp_valid, ch_rsp_ready;
  logic [NUM_CH*BK_W-1:0]     rob_bank_id, ch_rsp_bank_id;
  logic [NUM_CH*DATA_W-1:0]   ch_rsp_data;
  logic                       rsp_err;

  int errors = 0;
  int checks = 0;

  cache_rsp_return dut (
    .clk(clk), .rstn(rstn),
    .bank_rsp_valid(bank_rsp_valid), .bank_rsp_ready(bank_rsp_ready),
    .bank_rsp_ch_id(bank_rsp_ch_id), .bank_rsp_data(bank_rsp_data),
    .rob_req(rob_req), .rob_bank_id(rob_bank_id), .rob_ack(rob_ack),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_ready(ch_rsp_ready),
    .ch_rsp_data(ch_rsp_data), .ch_rsp_bank_id(ch_rsp_bank_id),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq [NUM_BANK][NUM_CH][$];
  logic              mv [NUM_CH];
  logic [DATA_W-1:0] md [NUM_CH];
  logic [BK_W-1:0]   mb [NUM_CH];
  logic              merr;
  int                stall_n [NUM_CH];
  logic              m_pop [NUM_CH];
  logic              m_push [NUM_BANK];

  function automatic int in_ch(int b);
    return int'(bank_rsp_ch_id[b*CH_W +: CH_W]);
  endfunction

  function automatic int rob_bk(int c);
    return int'(rob_bank_id[c*BK_W +: BK_W]);
  endfunction

  function automatic logic exp_ready(int b);
    int ch = in_ch(b);
    if (ch >= NUM_CH) return 1'b1;
    return (mq[b][ch].size() < RSP_DEPTH);
  endfunction

  function automatic logic exp_ack(int c);
    return rob_req[c] && (mq[rob_bk(c)][c].size() != 0) && (!mv[c] || ch_rsp_ready[c]);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < NUM_BANK; b++)
        for (int c = 0; c < NUM_CH; c++) mq[b][c].delete();
      for (int c = 0; c < NUM_CH; c++) begin
        mv[c] = 1'b0; md[c] = '0; mb[c] = '0; stall_n[c] = 0;
      end
      merr = 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) m_pop[c] = exp_ack(c);
      for (int b = 0; b < NUM_BANK; b++) m_push[b] = bank_rsp_valid[b] && exp_ready(b);
      for (int c = 0; c < NUM_CH; c++) begin
        if (rob_req[c] && mv[c] && !ch_rsp_ready[c]) begin
          stall_n[c]++;
          if (ERR_EN && stall_n[c] > 255) merr = 1'b1;
        end else stall_n[c] = 0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_pop[c]) begin
          md[c] = mq[rob_bk(c)][c].pop_front();
          mb[c] = BK_W'(rob_bk(c));
          mv[c] = 1'b1;
        end else if (ch_rsp_ready[c]) mv[c] = 1'b0;
      end
      for (int b = 0; b < NUM_BANK; b++) begin
        if (m_push[b]) begin
          if (in_ch(b) < NUM_CH) mq[b][in_ch(b)].push_back(bank_rsp_data[b*DATA_W +: DATA_W]);
          else if (ERR_EN) merr = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bank_rsp_valid = '0; bank_rsp_ch_id = '0; bank_rsp_data = '0;
    rob_req = '0; rob_bank_id = '0; ch_rsp_ready = '0;
  endtask

  task automatic set_beat(input int b, input int ch, input logic [DATA_W-1:0] d);
    bank_rsp_valid[b] = 1'b1;
    bank_rsp_ch_id[b*CH_W +: CH_W] = CH_W'(ch);
    bank_rsp_data[b*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_rob(input int c, input int b);
    rob_req[c] = 1'b1;
    rob_bank_id[c*BK_W +: BK_W] = BK_W'(b);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (ch_rsp_valid !== 3'b000 || ch_rsp_data !== '0 || ch_rsp_bank_id !== '0) begin
      errors++; $display("FAIL reset_out valid=%b data=%h bank=%h want all 0", ch_rsp_valid, ch_rsp_data, ch_rsp_bank_id);
    end
    checks++;
    if (bank_rsp_ready !== 4'hF || rob_ack !== 3'b000 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_ctl ready=%b ack=%b err=%b want 1111/000/0", bank_rsp_ready, rob_ack, rsp_err);
    end
    cyc();
    rstn = 1'b1;
    cyc();
    $display("txn reset released");
  endtask

  task automatic test_single();
    idle_inputs();
    set_beat(1, 0, 32'hA5A5_0001);
    set_rob(0, 1);
    ch_rsp_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (rob_ack !== 3'b000 || bank_rsp_ready[1] !== 1'b1) begin
      errors++; $display("FAIL t1_pre ack=%b ready1=%b want 000/1", rob_ack, bank_rsp_ready[1]);
    end
    cyc();
    bank_rsp_valid = '0;
    @(negedge clk);
    checks++;
    if (rob_ack !== 3'b001) begin errors++; $display("FAIL t1_ack got=%b want=001", rob_ack); end
    cyc();
    @(negedge clk);
    checks++;
    if (ch_rsp_valid[0] !== 1'b1 || ch_rsp_data[31:0] !== 32'hA5A5_0001 || ch_rsp_bank_id[1:0] !== 2'd1 || rob_ack !== 3'b000) begin
      errors++; $display("FAIL t1_out valid=%b data=%h bank=%0d ack=%b want 1/a5a50001/1/000",
                         ch_rsp_valid[0], ch_rsp_data[31:0], ch_rsp_bank_id[1:0], rob_ack);
    end
    $display("txn t1 ch0 data=%h", ch_rsp_data[31:0]);
    rob_req = '0;
    cyc();
    @(negedge clk);
    checks++;
    if (ch_rsp_valid !== 3'b000) begin errors++; $display("FAIL t1_drop valid=%b want=000", ch_rsp_valid); end
    cyc();
  endtask

  task automatic test_out_of_order();
    int acks = 0;
    idle_inputs();
    set_beat(2, 1, 32'h22);
    cyc();
    idle_inputs();
    set_beat(0, 1, 32'h00);
    cyc();
    idle_inputs();
    set_rob(1, 0);
    ch_rsp_ready[1] = 1'b1;
    @(negedge clk);
    acks += int'(rob_ack[1]);
    cyc();
    set_rob(1, 2);
    @(negedge clk);
    acks += int'(rob_ack[1]);
    checks++;
    if (ch_rsp_valid[1] !== 1'b1 || ch_rsp_data[63:32] !== 32'h00 || ch_rsp_bank_id[3:2] !== 2'd0) begin
      errors++; $display("FAIL t2_first valid=%b data=%h bank=%0d want 1/0/0", ch_rsp_valid[1], ch_rsp_data[63:32], ch_rsp_bank_id[3:2]);
    end
    $display("txn t2 ch1 data=%h bank=%0d", ch_rsp_data[63:32], ch_rsp_bank_id[3:2]);
    cyc();
    @(negedge clk);
    acks += int'(rob_ack[1]);
    checks++;
    if (ch_rsp_valid[1] !== 1'b1 || ch_rsp_data[63:32] !== 32'h22 || ch_rsp_bank_id[3:2] !== 2'd2) begin
      errors++; $display("FAIL t2_second valid=%b data=%h bank=%0d want 1/22/2", ch_rsp_valid[1], ch_rsp_data[63:32], ch_rsp_bank_id[3:2]);
    end
    $display("txn t2 ch1 data=%h bank=%0d", ch_rsp_data[63:32], ch_rsp_bank_id[3:2]);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      acks += int'(rob_ack[1]);
    end
    checks++;
    if (acks != 2) begin errors++; $display("FAIL t2_ack_count got=%0d want=2", acks); end
    rob_req = '0;
    cyc();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    set_beat(3, 2, 32'h31);
    cyc();
    set_beat(3, 2, 32'h32);
    @(negedge clk);
    checks++;
    if (bank_rsp_ready[3] !== 1'b1) begin errors++; $display("FAIL t3_half ready3=%b want=1", bank_rsp_ready[3]); end
    cyc();
    bank_rsp_valid = '0;
    @(negedge clk);
    checks++;
    if (bank_rsp_ready[3] !== 1'b0) begin errors++; $display("FAIL t3_full ready3=%b want=0", bank_rsp_ready[3]); end
    bank_rsp_ch_id[7:6] = 2'd0;
    #1;
    checks++;
    if (bank_rsp_ready[3] !== 1'b1) begin errors++; $display("FAIL t3_other_ch ready3=%b want=1", bank_rsp_ready[3]); end
    cyc();
    set_rob(2, 3);
    ch_rsp_ready[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (rob_ack !== 3'b100) begin errors++; $display("FAIL t3_pop1 ack=%b want=100", rob_ack); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (ch_rsp_valid[2] !== 1'b1 || ch_rsp_data[95:64] !== 32'h31 || ch_rsp_bank_id[5:4] !== 2'd3 || rob_ack !== 3'b000) begin
        errors++; $display("FAIL t3_hold cyc=%0d valid=%b data=%h bank=%0d ack=%b want 1/31/3/000",
                           i, ch_rsp_valid[2], ch_rsp_data[95:64], ch_rsp_bank_id[5:4], rob_ack);
      end
    end
    cyc();
    ch_rsp_ready[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (rob_ack !== 3'b100) begin errors++; $display("FAIL t3_pop2 ack=%b want=100", rob_ack); end
    cyc();
    rob_req = '0;
    @(negedge clk);
    checks++;
    if (ch_rsp_valid[2] !== 1'b1 || ch_rsp_data[95:64] !== 32'h32) begin
      errors++; $display("FAIL t3_second valid=%b data=%h want 1/32", ch_rsp_valid[2], ch_rsp_data[95:64]);
    end
    $display("txn t3 ch2 data=%h", ch_rsp_data[95:64]);
    cyc();
    @(negedge clk);
    checks++;
    if (ch_rsp_valid[2] !== 1'b0) begin errors++; $display("FAIL t3_drop valid=%b want=0", ch_rsp_valid[2]); end
    cyc();
  endtask

  task automatic test_parallel();
    logic [NUM_CH*DATA_W-1:0] want_d;
    logic [NUM_CH*BK_W-1:0]   want_b;
    idle_inputs();
    set_beat(3, 0, 32'h40); set_beat(0, 1, 32'h41); set_beat(1, 2, 32'h42);
    cyc();
    idle_inputs();
    set_beat(0, 2, 32'h50); set_beat(1, 0, 32'h51); set_beat(2, 1, 32'h52);
    set_rob(0, 3); set_rob(1, 0); set_rob(2, 1);
    ch_rsp_ready = 3'b111;
    @(negedge clk);
    checks++;
    if (rob_ack !== 3'b111 || bank_rsp_ready[2:0] !== 3'b111) begin
      errors++; $display("FAIL t4_acks ack=%b ready=%b want 111/111", rob_ack, bank_rsp_ready[2:0]);
    end
    cyc();
    bank_rsp_valid = '0;
    set_rob(0, 1); set_rob(1, 2); set_rob(2, 0);
    @(negedge clk);
    want_d = {32'h42, 32'h41, 32'h40};
    want_b = {2'd1, 2'd0, 2'd3};
    checks++;
    if (ch_rsp_valid !== 3'b111 || ch_rsp_data !== want_d || ch_rsp_bank_id !== want_b || rob_ack !== 3'b111) begin
      errors++; $display("FAIL t4_round1 valid=%b data=%h bank=%h ack=%b want 111/%h/%h/111",
                         ch_rsp_valid, ch_rsp_data, ch_rsp_bank_id, rob_ack, want_d, want_b);
    end
    $display("txn t4 round1 data=%h", ch_rsp_data);
    cyc();
    rob_req = '0;
    @(negedge clk);
    want_d = {32'h50, 32'h52, 32'h51};
    want_b = {2'd0, 2'd2, 2'd1};
    checks++;
    if (ch_rsp_valid !== 3'b111 || ch_rsp_data !== want_d || ch_rsp_bank_id !== want_b) begin
      errors++; $display("FAIL t4_round2 valid=%b data=%h bank=%h want 111/%h/%h", ch_rsp_valid, ch_rsp_data, ch_rsp_bank_id, want_d, want_b);
    end
    $display("txn t4 round2 data=%h", ch_rsp_data);
    cyc();
    set_rob(0, 1); set_rob(1, 2); set_rob(2, 0);
    @(negedge clk);
    checks++;
    if (rob_ack !== 3'b000 || ch_rsp_valid !== 3'b000 || bank_rsp_ready !== 4'hF) begin
      errors++; $display("FAIL t4_empty ack=%b valid=%b ready=%b want 000/000/1111", rob_ack, ch_rsp_valid, bank_rsp_ready);
    end
    rob_req = '0;
    cyc();
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    set_beat(0, 0, 32'h61);
    cyc();
    set_beat(0, 0, 32'h62); set_beat(2, 1, 32'h63);
    cyc();
    bank_rsp_valid = '0;
    set_rob(0, 0);
    cyc();
    @(negedge clk);
    checks++;
    if (ch_rsp_valid[0] !== 1'b1 || ch_rsp_data[31:0] !== 32'h61) begin
      errors++; $display("FAIL t5_pre valid=%b data=%h want 1/61", ch_rsp_valid[0], ch_rsp_data[31:0]);
    end
    ch_rsp_ready = 3'b111;
    set_rob(1, 2);
    rstn = 1'b0;
    #1;
    checks++;
    if (ch_rsp_valid !== 3'b000 || ch_rsp_data !== '0 || ch_rsp_bank_id !== '0 || rob_ack !== 3'b000
        || bank_rsp_ready !== 4'hF || rsp_err !== 1'b0) begin
      errors++; $display("FAIL t5_in_reset valid=%b data=%h bank=%h ack=%b ready=%b err=%b want zeros/ready 1111",
                         ch_rsp_valid, ch_rsp_data, ch_rsp_bank_id, rob_ack, bank_rsp_ready, rsp_err);
    end
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rob_ack !== 3'b000 || ch_rsp_valid !== 3'b000) begin
        errors++; $display("FAIL t5_after cyc=%0d ack=%b valid=%b want 000/000", i, rob_ack, ch_rsp_valid);
      end
      cyc();
    end
    set_beat(0, 0, 32'h70);
    cyc();
    bank_rsp_valid = '0;
    @(negedge clk);
    checks++;
    if (rob_ack !== 3'b001) begin errors++; $display("FAIL t5_new_ack ack=%b want=001", rob_ack); end
    cyc();
    @(negedge clk);
    checks++;
    if (ch_rsp_valid[0] !== 1'b1 || ch_rsp_data[31:0] !== 32'h70) begin
      errors++; $display("FAIL t5_new_out valid=%b data=%h want 1/70", ch_rsp_valid[0], ch_rsp_data[31:0]);
    end
    $display("txn t5 ch0 data=%h", ch_rsp_data[31:0]);
    idle_inputs();
    ch_rsp_ready = 3'b111;
    cyc();
  endtask

  task automatic test_illegal_ch();
    idle_inputs();
    set_beat(0, 3, 32'hDEAD);
    set_rob(0, 0);
    ch_rsp_ready = 3'b111;
    @(negedge clk);
    checks++;
    if (bank_rsp_ready[0] !== 1'b1) begin errors++; $display("FAIL t6_ready ready0=%b want=1", bank_rsp_ready[0]); end
    cyc();
    bank_rsp_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_err !== ERR_EN || rob_ack !== 3'b000 || ch_rsp_valid !== 3'b000) begin
        errors++; $display("FAIL t6_err cyc=%0d err=%b ack=%b valid=%b want %b/000/000", i, rsp_err, rob_ack, ch_rsp_valid, ERR_EN);
      end
      cyc();
    end
    $display("txn t6 illegal beat dropped err=%b", rsp_err);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL t6_err_reset err=%b want=0", rsp_err); end
    cyc();
    rstn = 1'b1;
    idle_inputs();
    cyc();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        bank_rsp_valid[b] = $urandom_range(0, 1) == 1;
        bank_rsp_ch_id[b*CH_W +: CH_W] = ($urandom_range(0, 15) == 0) ? 2'd3 : CH_W'($urandom_range(0, 2));
        bank_rsp_data[b*DATA_W +: DATA_W] = $urandom;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        rob_req[c] = $urandom_range(0, 3) != 0;
        rob_bank_id[c*BK_W +: BK_W] = BK_W'($urandom_range(0, NUM_BANK - 1));
        ch_rsp_ready[c] = $urandom_range(0, 3) != 0;
      end
      @(negedge clk);
      for (int b = 0; b < NUM_BANK; b++) begin
        checks++;
        if (bank_rsp_ready[b] !== exp_ready(b)) begin
          errors++; $display("FAIL rnd_ready n=%0d bank=%0d got=%b want=%b", n, b, bank_rsp_ready[b], exp_ready(b));
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        checks++;
        if (rob_ack[c] !== exp_ack(c)) begin
          errors++; $display("FAIL rnd_ack n=%0d ch=%0d got=%b want=%b", n, c, rob_ack[c], exp_ack(c));
        end
        checks++;
        if (ch_rsp_valid[c] !== mv[c] || (mv[c] && (ch_rsp_data[c*DATA_W +: DATA_W] !== md[c]
            || ch_rsp_bank_id[c*BK_W +: BK_W] !== mb[c]))) begin
          errors++; $display("FAIL rnd_out n=%0d ch=%0d valid=%b data=%h bank=%0d want %b/%h/%0d", n, c, ch_rsp_valid[c],
                             ch_rsp_data[c*DATA_W +: DATA_W], ch_rsp_bank_id[c*BK_W +: BK_W], mv[c], md[c], mb[c]);
        end
        if (ch_rsp_valid[c] && ch_rsp_ready[c])
          $display("txn rnd n=%0d ch%0d bank%0d data=%h", n, c, ch_rsp_bank_id[c*BK_W +: BK_W], ch_rsp_data[c*DATA_W +: DATA_W]);
      end
      checks++;
      if (rsp_err !== merr) begin errors++; $display("FAIL rnd_err n=%0d got=%b want=%b", n, rsp_err, merr); end
      cyc();
    end
    idle_inputs();
    cyc();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    test_reset();
    test_single();
    test_out_of_order();
    test_backpressure();
    test_parallel();
    test_reset_midstream();
    test_illegal_ch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
